// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB3 initiator.
package apb_master_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Width of the read-data field held in the response register.
    localparam int RSP_DATA_W = DEF_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // True in the states where the initiator owns the APB bus.
    function automatic logic apb_bus_active(apb_state_e s);
        return (s == ST_SETUP) || (s == ST_ACCESS);
    endfunction

endpackage

// File: rtl/apb_master_wait_timer.sv
// Saturating counter of ACCESS cycles spent waiting for PREADY.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise step once per stalled cycle and stick at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != CW'(TIMEOUT_CYCLES))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count holds the number of stalled cycles already behind us, so once it
    // reaches TIMEOUT_CYCLES-1 the current ACCESS cycle is the last one allowed.
    assign expired = (count_q >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: one command in, one APB transfer out, one response back.
// Handshakes: a command moves when cmd_valid && cmd_ready on a PCLK edge; a
// response moves when rsp_valid && rsp_ready on a PCLK edge. All outputs are flops.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSELx,
    output logic              PENABLE,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    apb_rsp_t          rsp_q, rsp_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (timer_clear),
        .count_en(timer_en),
        .expired (timer_expired)
    );

    // Next-state, captured command/response and registered bus controls.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_d       = rsp_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                timer_clear = 1'b1;
                state_d     = ST_ACCESS;
            end
            ST_ACCESS: begin
                timer_en = !PREADY;
                // PREADY on the final allowed cycle still wins over the timeout.
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : RSP_DATA_W'(PRDATA);
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = ST_RESP;
                end else if (timer_expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus and handshake outputs are decoded from the next state so they
        // come straight out of flops and line up with the state they describe.
        psel_d      = apb_bus_active(state_d);
        penable_d   = (state_d == ST_ACCESS);
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset drops the bus and discards any response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = DATA_W'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;

endmodule
